// File: rtl/intra_recon_stream_if.sv
// intra_recon_stream_if: residue-row input stream and reconstructed-row output stream
// master: producer of residue rows / consumer of reconstructed rows
// slave : the reconstruction engine
interface intra_recon_stream_if #(
  parameter int NCH   = 3,
  parameter int BLK   = 4,
  parameter int RES_W = 9
);
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
  logic                 s_valid;
  logic                 s_ready;
  logic [CHW-1:0]       s_ch;
  logic [1:0]           s_mode;
  logic                 s_sof;
  logic [BLK*RES_W-1:0] s_res;
  logic                 m_valid;
  logic                 m_ready;
  logic [CHW-1:0]       m_ch;
  logic                 m_last;
  logic [BLK*8-1:0]     m_pix;
  logic [NCH-1:0]       frame_done;
  logic                 mode_err;
  modport master (
    output s_valid, s_ch, s_mode, s_sof, s_res, m_ready,
    input  s_ready, m_valid, m_ch, m_last, m_pix, frame_done, mode_err
  );
  modport slave (
    input  s_valid, s_ch, s_mode, s_sof, s_res, m_ready,
    output s_ready, m_valid, m_ch, m_last, m_pix, frame_done, mode_err
  );
endinterface

// File: rtl/intra_recon_stream.sv
// intra_recon_stream: multi-channel streaming intra prediction, residue add and clip
// clk, reset : clock and asynchronous active-high reset
// io (slave) : s_* residue rows in (ch/mode/sof on first beat), m_* reconstructed rows out,
//              frame_done per-channel end-of-frame pulse, sticky mode_err
module intra_recon_stream #(
  parameter int NCH    = 3,
  parameter int BLK    = 4,
  parameter int LINE_W = 1280,
  parameter int LINES  = 720,
  parameter int RES_W  = 9
) (
  input logic clk,
  input logic reset,
  intra_recon_stream_if.slave io
);
  localparam int NBX = LINE_W / BLK;
  localparam int NBY = LINES / BLK;
  localparam int BXW = NBX > 1 ? $clog2(NBX) : 1;
  localparam int BYW = NBY > 1 ? $clog2(NBY) : 1;
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int LB  = $clog2(BLK);
  localparam int SW  = LB + 10;
  typedef enum logic [1:0] {IDLE, PRED, ROWS} state_t;
  state_t r_state, w_next;
  logic [CHW-1:0] r_ch, r_mch;
  logic [1:0] r_mode, r_pm, w_pm;
  logic r_sof, r_mvalid, r_mlast, r_fend, r_merr;
  logic [BXW-1:0] r_bx [NCH];
  logic [BYW-1:0] r_by [NCH];
  logic [BXW-1:0] r_cbx, w_bx;
  logic [BYW-1:0] r_cby, w_by;
  logic [LB-1:0] r_row;
  logic [BLK*8-1:0] r_line [NCH][NBX];
  logic [BLK*8-1:0] r_left [NCH];
  logic [BLK*8-1:0] r_top, r_lft, r_mpix, w_top, w_left, w_pix;
  logic [7:0] r_dc, w_dc, w_p;
  logic [SW-1:0] w_st, w_sl;
  logic signed [RES_W+1:0] w_s;
  logic w_tav, w_lav, w_rdy, w_acc, w_lastrow, w_xw, w_yw;
  // sof restarts the channel at the frame origin before neighbours are fetched
  assign w_bx = r_sof ? '0 : r_bx[r_ch];
  assign w_by = r_sof ? '0 : r_by[r_ch];
  assign w_top = r_line[r_ch][w_bx];
  assign w_left = r_left[r_ch];
  assign w_tav = w_by != '0;
  assign w_lav = w_bx != '0;
  // directional modes without their neighbour degrade to DC
  assign w_pm = (r_mode == 2'd0 && w_tav) ? 2'd0 : (r_mode == 2'd1 && w_lav) ? 2'd1 : 2'd2;
  assign w_lastrow = r_row == LB'(BLK - 1);
  assign w_xw = r_cbx == BXW'(NBX - 1);
  assign w_yw = r_cby == BYW'(NBY - 1);
  always_comb begin
    w_st = '0;
    w_sl = '0;
    for (int i = 0; i < BLK; i++) begin
      w_st = w_st + SW'(w_top[i*8 +: 8]);
      w_sl = w_sl + SW'(w_left[i*8 +: 8]);
    end
    w_dc = 8'(w_tav && w_lav ? (w_st + w_sl + SW'(BLK)) >> (LB + 1) :
              w_tav ? (w_st + SW'(BLK / 2)) >> LB :
              w_lav ? (w_sl + SW'(BLK / 2)) >> LB : SW'(128));
  end
  // add at RES_W+2 signed so p+res never wraps before the clip
  always_comb begin
    w_pix = '0;
    w_p = '0;
    w_s = '0;
    for (int c = 0; c < BLK; c++) begin
      w_p = r_pm == 2'd0 ? r_top[c*8 +: 8] : r_pm == 2'd1 ? r_lft[r_row*8 +: 8] : r_dc;
      w_s = $signed({{(RES_W-6){1'b0}}, w_p}) + $signed({{2{io.s_res[c*RES_W+RES_W-1]}}, io.s_res[c*RES_W +: RES_W]});
      w_pix[c*8 +: 8] = w_s[RES_W+1] ? 8'd0 : |w_s[RES_W:8] ? 8'd255 : w_s[7:0];
    end
  end
  always_comb begin
    w_rdy = r_state == ROWS && (!r_mvalid || io.m_ready);
    w_acc = w_rdy && io.s_valid;
    w_next = r_state == IDLE ? (io.s_valid ? PRED : IDLE) :
             r_state == PRED ? ROWS : (w_acc && w_lastrow) ? IDLE : ROWS;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ch <= '0;
      r_mode <= '0;
      r_sof <= 1'b0;
      r_pm <= '0;
      r_cbx <= '0;
      r_cby <= '0;
      r_top <= '0;
      r_lft <= '0;
      r_dc <= '0;
      r_row <= '0;
      r_mvalid <= 1'b0;
      r_mlast <= 1'b0;
      r_mch <= '0;
      r_mpix <= '0;
      r_fend <= 1'b0;
      r_merr <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_bx[i] <= '0;
        r_by[i] <= '0;
      end
    end else begin
      if (r_state == IDLE && io.s_valid) begin
        r_ch <= io.s_ch;
        r_mode <= io.s_mode;
        r_sof <= io.s_sof;
      end
      if (r_state == PRED) begin
        r_cbx <= w_bx;
        r_cby <= w_by;
        r_top <= w_top;
        r_lft <= w_left;
        r_dc <= w_dc;
        r_pm <= w_pm;
        r_row <= '0;
        if (r_mode == 2'd3) r_merr <= 1'b1;
      end
      if (w_acc) begin
        r_row <= r_row + 1'b1;
        r_mvalid <= 1'b1;
        r_mpix <= w_pix;
        r_mlast <= w_lastrow;
        r_mch <= r_ch;
        r_fend <= w_lastrow && w_xw && w_yw;
        if (w_lastrow) begin
          r_bx[r_ch] <= w_xw ? '0 : r_cbx + 1'b1;
          r_by[r_ch] <= w_xw ? (w_yw ? '0 : r_cby + 1'b1) : r_cby;
        end
      end else if (io.m_ready) r_mvalid <= 1'b0;
    end
  // neighbour storage: contents only read once the matching availability flag is set
  always_ff @(posedge clk)
    if (w_acc) begin
      r_left[r_ch][r_row*8 +: 8] <= w_pix[(BLK-1)*8 +: 8];
      if (w_lastrow) r_line[r_ch][r_cbx] <= w_pix;
    end
  assign io.s_ready = w_rdy;
  assign io.m_valid = r_mvalid;
  assign io.m_last = r_mlast;
  assign io.m_ch = r_mch;
  assign io.m_pix = r_mpix;
  assign io.mode_err = r_merr;
  assign io.frame_done = (r_mvalid && io.m_ready && r_mlast && r_fend) ? NCH'(1) << r_mch : '0;
endmodule

// File: tb/tb_intra_recon_stream.sv
// tb_intra_recon_stream: directed block vectors on an 8x8 three-channel frame, plus stall/reset/mode-3 sequences
module tb_intra_recon_stream;
  localparam int NCH = 3;
  localparam int BLK = 4;
  localparam int LW = 8;
  localparam int LN = 8;
  localparam int RW = 10;
  typedef struct packed {
    logic [1:0] ch;
    logic [1:0] mode;
    logic sof;
    logic [3:0][39:0] res;
    logic [3:0][31:0] pix;
    logic [2:0] fd;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t vecs[11];
  vec_t vk, vm;
  logic [31:0] q_pix[$];
  logic [5:0] q_ctl[$];
  intra_recon_stream_if #(.NCH(NCH), .BLK(BLK), .RES_W(RW)) io();
  intra_recon_stream #(.NCH(NCH), .BLK(BLK), .LINE_W(LW), .LINES(LN), .RES_W(RW)) dut (
    .clk(clk), .reset(reset), .io(io)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!reset && io.m_valid && io.m_ready) begin
      q_pix.push_back(io.m_pix);
      q_ctl.push_back({io.m_ch, io.m_last, io.frame_done});
    end
  function automatic logic [39:0] pr(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction
  function automatic logic [31:0] pp(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction
  function automatic vec_t mk(input int ch, input int mode, input int sof,
                              input logic [39:0] r0, input logic [39:0] r1, input logic [39:0] r2, input logic [39:0] r3,
                              input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                              input int fd);
    vec_t v;
    v.ch = 2'(ch);
    v.mode = 2'(mode);
    v.sof = 1'(sof);
    v.res[0] = r0; v.res[1] = r1; v.res[2] = r2; v.res[3] = r3;
    v.pix[0] = p0; v.pix[1] = p1; v.pix[2] = p2; v.pix[3] = p3;
    v.fd = 3'(fd);
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic send_block(input vec_t v);
    bit hs;
    int n;
    @(posedge clk); #1;
    io.s_valid = 1'b1;
    io.s_ch = v.ch;
    io.s_mode = v.mode;
    io.s_sof = v.sof;
    for (int r = 0; r < BLK; r++) begin
      io.s_res = v.res[r];
      n = 0;
      hs = 1'b0;
      while (!hs && n < 50) begin
        @(negedge clk);
        hs = io.s_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout row %0d", r);
      end
      io.s_ch = (v.ch == 2'd2) ? 2'd0 : v.ch + 2'd1;
      io.s_mode = 2'd3;
      io.s_sof = 1'b1;
    end
    io.s_valid = 1'b0;
  endtask
  task automatic check_block(input vec_t v, input string nm);
    int n;
    n = 0;
    while (q_pix.size() < BLK && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({nm, " rows"}, 64'(q_pix.size()), 64'(BLK));
    for (int r = 0; r < BLK && q_pix.size() > 0; r++) begin
      chk($sformatf("%s pix%0d", nm, r), 64'(q_pix.pop_front()), 64'(v.pix[r]));
      chk($sformatf("%s ctl%0d", nm, r), 64'(q_ctl.pop_front()), 64'({v.ch, r == BLK - 1, r == BLK - 1 ? v.fd : 3'd0}));
    end
    q_pix.delete();
    q_ctl.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    io.s_valid = 1'b0;
    io.s_ch = '0;
    io.s_mode = '0;
    io.s_sof = 1'b0;
    io.s_res = '0;
    io.m_ready = 1'b1;
    vecs[0] = mk(0, 0, 1, pr(0,0,0,0), pr(0,0,0,0), pr(0,0,0,0), pr(0,0,0,0),
                 pp(128,128,128,128), pp(128,128,128,128), pp(128,128,128,128), pp(128,128,128,128), 0);
    vecs[1] = mk(0, 2, 1, pr(0,0,0,-118), pr(0,0,0,-108), pr(0,0,0,-98), pr(0,0,0,-88),
                 pp(128,128,128,10), pp(128,128,128,20), pp(128,128,128,30), pp(128,128,128,40), 0);
    vecs[2] = mk(1, 2, 1, pr(127,127,127,127), pr(127,127,127,127), pr(127,127,127,127), pr(127,127,127,127),
                 pp(255,255,255,255), pp(255,255,255,255), pp(255,255,255,255), pp(255,255,255,255), 0);
    vecs[3] = mk(0, 1, 0, pr(5,5,5,5), pr(5,5,5,5), pr(5,5,5,5), pr(5,5,5,5),
                 pp(15,15,15,15), pp(25,25,25,25), pp(35,35,35,35), pp(45,45,45,45), 0);
    vecs[4] = mk(1, 2, 0, pr(100,-300,0,0), pr(100,-300,0,0), pr(100,-300,0,0), pr(0,0,0,0),
                 pp(255,0,255,255), pp(255,0,255,255), pp(255,0,255,255), pp(255,255,255,255), 0);
    vecs[5] = mk(2, 1, 1, pr(1,2,3,4), pr(1,2,3,4), pr(1,2,3,4), pr(1,2,3,4),
                 pp(129,130,131,132), pp(129,130,131,132), pp(129,130,131,132), pp(129,130,131,132), 0);
    vecs[6] = mk(0, 0, 0, pr(0,0,0,0), pr(1,-1,0,2), pr(2,-2,0,4), pr(3,-3,0,6),
                 pp(128,128,128,40), pp(129,127,128,42), pp(130,126,128,44), pp(131,125,128,46), 0);
    vecs[7] = mk(2, 1, 0, pr(0,0,0,0), pr(0,0,0,0), pr(0,0,0,0), pr(0,0,0,0),
                 pp(132,132,132,132), pp(132,132,132,132), pp(132,132,132,132), pp(132,132,132,132), 0);
    vecs[8] = mk(1, 0, 0, pr(-5,-10,-255,0), pr(-5,-10,-255,0), pr(-5,-10,-255,0), pr(-5,-10,-255,0),
                 pp(250,245,0,255), pp(250,245,0,255), pp(250,245,0,255), pp(250,245,0,255), 0);
    vecs[9] = mk(0, 2, 0, pr(0,0,0,0), pr(0,0,0,0), pr(0,0,0,0), pr(0,0,0,0),
                 pp(44,44,44,44), pp(44,44,44,44), pp(44,44,44,44), pp(44,44,44,44), 1);
    vecs[10] = mk(1, 2, 0, pr(100,-300,511,-512), pr(100,-300,511,-512), pr(100,-300,511,-512), pr(100,-300,511,-512),
                  pp(255,0,255,0), pp(255,0,255,0), pp(255,0,255,0), pp(255,0,255,0), 2);
    vk = mk(2, 0, 0, pr(0,0,0,0), pr(1,1,1,1), pr(2,2,2,2), pr(3,3,3,3),
            pp(129,130,131,132), pp(130,131,132,133), pp(131,132,133,134), pp(132,133,134,135), 0);
    vm = mk(2, 3, 0, pr(0,0,0,0), pr(1,0,0,0), pr(2,0,0,0), pr(3,0,0,0),
            pp(128,128,128,128), pp(129,128,128,128), pp(130,128,128,128), pp(131,128,128,128), 0);
    #2;
    chk("rst s_ready", 64'(io.s_ready), 64'(0));
    chk("rst m_valid", 64'(io.m_valid), 64'(0));
    chk("rst m_last", 64'(io.m_last), 64'(0));
    chk("rst m_pix", 64'(io.m_pix), 64'(0));
    chk("rst m_ch", 64'(io.m_ch), 64'(0));
    chk("rst frame_done", 64'(io.frame_done), 64'(0));
    chk("rst mode_err", 64'(io.mode_err), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      send_block(vecs[i]);
      check_block(vecs[i], $sformatf("blk%0d", i));
    end
    fork
      send_block(vk);
      begin : stall
        int c, n;
        c = 0;
        n = 0;
        while (c < 2 && n < 100) begin
          @(negedge clk);
          if (io.m_valid && io.m_ready) c++;
          n++;
        end
        chk("stall arm", 64'(c), 64'(2));
        @(posedge clk); #1;
        io.m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall m_valid", 64'(io.m_valid), 64'(1));
          chk("stall m_pix", 64'(io.m_pix), 64'(vk.pix[2]));
          chk("stall s_ready", 64'(io.s_ready), 64'(0));
        end
        @(posedge clk); #1;
        io.m_ready = 1'b1;
      end
    join
    check_block(vk, "stall_blk");
    @(posedge clk); #1;
    io.s_valid = 1'b1;
    io.s_ch = 2'd0;
    io.s_mode = 2'd2;
    io.s_sof = 1'b0;
    io.s_res = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst m_valid", 64'(io.m_valid), 64'(1));
    chk("pre_rst m_last", 64'(io.m_last), 64'(0));
    chk("pre_rst m_pix", 64'(io.m_pix), 64'(pp(128,128,128,128)));
    chk("pre_rst mode_err", 64'(io.mode_err), 64'(0));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst m_valid", 64'(io.m_valid), 64'(0));
    chk("mid_rst s_ready", 64'(io.s_ready), 64'(0));
    chk("mid_rst m_pix", 64'(io.m_pix), 64'(0));
    chk("mid_rst m_last", 64'(io.m_last), 64'(0));
    io.s_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q_pix.delete();
    q_ctl.delete();
    send_block(vm);
    check_block(vm, "mode3_blk");
    chk("mode_err set", 64'(io.mode_err), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
